// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - mid-bit sampling 10-bit serial frame receiver (optional RX_SYNC_EN input synchronizer)
module serial_frame_receiver #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int FRAME_BITS      = 10,
  parameter int MID_SAMPLE      = SAMPLES_PER_BIT / 2 - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_enable,
  input  logic                  data_in,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  charReceived,
  output logic                  frameErr,
  output logic                  busy
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] MID_C  = CW'(MID_SAMPLE);
  localparam logic [CW-1:0] LAST_C = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(FRAME_BITS - 2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [FRAME_BITS-2:0] shreg;
  logic                  prev_line;
  logic                  line;

`ifdef RX_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
    end
  end

  assign line = sync2;
`else
  assign line = data_in;
`endif

  // Receive FSM: start detect, mid-bit sampling, frame assembly and result strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      prev_line    <= 1'b0;
      data_out     <= '0;
      charReceived <= 1'b0;
      frameErr     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      prev_line    <= line;
      charReceived <= 1'b0;
      frameErr     <= 1'b0;
      if (!r_enable) begin
        state   <= IDLE;
        busy    <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            // counter sits at 0 on the edge cycle, so START counts from 1
            cnt <= '0;
            if (!line && prev_line) begin
              state <= START;
              busy  <= 1'b1;
              cnt   <= CW'(1);
            end
          end
          START: begin
            if (cnt == MID_C) begin
              cnt <= '0;
              if (!line) begin
                state    <= DATA;
                bit_idx  <= BW'(1);
                shreg[0] <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            // counter restarted at mid-bit, so its wrap point is the next mid-bit
            if (cnt == LAST_C) begin
              cnt            <= '0;
              shreg[bit_idx] <= line;
              bit_idx        <= bit_idx + BW'(1);
              if (bit_idx == LAST_DATA_BIT) begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == LAST_C) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              if (line) begin
                data_out     <= {1'b1, shreg};
                charReceived <= 1'b1;
              end else begin
                frameErr <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - randomized self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int SPB = 16;
  localparam int MID = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       r_enable;
  logic       data_in;
  logic [9:0] data_out;
  logic       charReceived;
  logic       frameErr;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk      = 0;

  serial_frame_receiver dut (
    .clk          (clk),
    .reset        (reset),
    .r_enable     (r_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .charReceived (charReceived),
    .frameErr     (frameErr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle", name, got, got, exp, exp);
    end
  endtask

  // Reference model: frame timing expressed as offsets from the start edge cycle
  int         ncyc = 0;
  int         c, off, k;
  bit         m_active = 0;
  int         m_t = 0;
  logic [9:0] m_frame = '0;
  logic [9:0] m_data = '0;
  logic       m_char = 0, m_ferr = 0, m_busy = 0, m_prev = 0;
  logic       m_s1 = 1, m_s2 = 1, ln;

  always @(posedge clk) begin
    c = ncyc;
    ncyc = ncyc + 1;
    if (LAT == 2) begin
      ln = m_s2;
      m_s2 = m_s1;
      m_s1 = data_in;
    end else begin
      ln = data_in;
    end
    m_char = 0;
    m_ferr = 0;
    if (reset) begin
      m_active = 0;
      m_data   = '0;
      m_prev   = 0;
      m_s1     = 1;
      m_s2     = 1;
    end else begin
      if (!r_enable) begin
        m_active = 0;
      end else if (!m_active) begin
        if (!ln && m_prev) begin
          m_active = 1;
          m_t      = c;
        end
      end else begin
        off = c - m_t;
        if (off == MID) begin
          if (ln) m_active = 0;
          else m_frame[0] = 1'b0;
        end else if (off > MID && (off - MID) % SPB == 0) begin
          k = (off - MID) / SPB;
          m_frame[k] = ln;
          if (k == 9) begin
            m_active = 0;
            if (ln) begin
              m_data = m_frame;
              m_char = 1;
            end else begin
              m_ferr = 1;
            end
          end
        end
      end
      m_prev = ln;
    end
    m_busy = m_active;
  end

  // Pulse bookkeeping and per-cycle comparison against the model
  int n_char = 0, n_ferr = 0;
  int last_char_cyc = -1, prev_char_cyc = -1, last_ferr_cyc = -1;

  always @(negedge clk) begin
    if (chk) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("charReceived", 32'(charReceived), 32'(m_char));
      check("frameErr", 32'(frameErr), 32'(m_ferr));
      check("data_out", 32'(data_out), 32'(m_data));
      if (charReceived) begin
        n_char++;
        prev_char_cyc = last_char_cyc;
        last_char_cyc = ncyc;
      end
      if (frameErr) begin
        n_ferr++;
        last_ferr_cyc = ncyc;
      end
    end
  end

  task automatic idle(input int n);
    data_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // kind 0: plain frame, 1: drop r_enable at cycle 'at', 2: one-cycle reset at 'at'
  task automatic send_frame_ev(input logic [9:0] f, input int kind, input int at);
    for (int i = 0; i < 160; i++) begin
      if (kind == 1 && at >= 0 && i == at + 1) check("abort_busy_low", 32'(busy), 0);
      if (i == at) begin
        if (kind == 1) r_enable = 1'b0;
        else if (kind == 2) reset = 1'b1;
      end else if (kind == 2) begin
        reset = 1'b0;
      end
      data_in = f[i/16];
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  initial begin
    int t0, nc, nf;
    logic [9:0] f;
    logic [9:0] frame_a;
    logic [9:0] frame_b;
    logic [9:0] frame_c;
    frame_a = 10'b1010110100;
    frame_b = 10'b1111111110;
    frame_c = 10'b1001100110;

    reset = 1'b1;
    r_enable = 1'b1;
    data_in = 1'b1;
    repeat (2) @(negedge clk);
    chk = 1;
    check("reset_data_out", 32'(data_out), 0);
    check("reset_char", 32'(charReceived), 0);
    check("reset_ferr", 32'(frameErr), 0);
    check("reset_busy", 32'(busy), 0);
    reset = 1'b0;
    idle(200);
    check("idle_no_char", n_char, 0);
    check("idle_no_ferr", n_ferr, 0);
    check("idle_busy", 32'(busy), 0);

    // good frame
    t0 = ncyc;
    send_frame_ev(frame_a, 0, -1);
    idle(10);
    check("good_count", n_char, 1);
    check("good_latency", last_char_cyc - t0, 152 + LAT);
    check("good_data", 32'(data_out), 32'(frame_a));
    check("model_good_data", 32'(m_data), 32'(frame_a));
    check("good_no_ferr", n_ferr, 0);

    // false start
    t0 = ncyc;
    data_in = 1'b0;
    repeat (4) @(negedge clk);
    data_in = 1'b1;
    repeat (3 + LAT) @(negedge clk);
    check("false_busy_t7", 32'(busy), 1);
    @(negedge clk);
    check("false_busy_t8", 32'(busy), 0);
    idle(20);
    check("false_no_char", n_char, 1);
    check("false_no_ferr", n_ferr, 0);
    check("false_data_kept", 32'(data_out), 32'(frame_a));

    // framing error, then line stuck low
    t0 = ncyc;
    send_frame_ev({1'b0, frame_a[8:0]}, 0, -1);
    repeat (40) @(negedge clk);
    check("ferr_count", n_ferr, 1);
    check("ferr_latency", last_ferr_cyc - t0, 152 + LAT);
    check("ferr_no_char", n_char, 1);
    check("ferr_data_kept", 32'(data_out), 32'(frame_a));
    check("stuck_low_busy", 32'(busy), 0);
    idle(20);

    // back-to-back
    send_frame_ev(frame_a, 0, -1);
    send_frame_ev(frame_b, 0, -1);
    idle(20);
    check("b2b_count", n_char, 3);
    check("b2b_spacing", last_char_cyc - prev_char_cyc, 160);
    check("b2b_data", 32'(data_out), 32'(frame_b));

    // abort via r_enable, then recover
    send_frame_ev(frame_a, 1, 60);
    idle(5);
    check("abort_no_char", n_char, 3);
    r_enable = 1'b1;
    idle(5);
    send_frame_ev(frame_c, 0, -1);
    idle(10);
    check("recover_count", n_char, 4);
    check("recover_data", 32'(data_out), 32'(frame_c));

    // randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      f = {($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)), 1'b0};
      if (r < 6) send_frame_ev(f, 0, -1);
      else if (r == 6) begin
        data_in = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
      end
      else if (r == 7) begin
        send_frame_ev(f, 1, $urandom_range(0, 159));
        r_enable = 1'b1;
      end
      else if (r == 8) send_frame_ev(f, 2, $urandom_range(0, 159));
      else idle($urandom_range(1, 30));
      idle($urandom_range(0, 4));
    end
    idle(200);

    nc = n_char;
    nf = n_ferr;
    idle(50);
    check("final_quiet_char", n_char, nc);
    check("final_quiet_ferr", n_ferr, nf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Serial receiver stage directly downstream of the 10-bit frame transmitter. It watches the transmitter's serial line and detects each start bit. Every bit is sampled at mid-bit using a per-bit clock-cycle counter, and the bits are reassembled into a 10-bit frame. Each good frame is presented in parallel with a one-cycle `charReceived` strobe. Framing errors are flagged and the frame is discarded.

## Interface
- `SAMPLES_PER_BIT`, 16: clock cycles per serial bit. Must be ≥ 4.
- `FRAME_BITS`, 10: bits per frame, start bit plus payload plus stop bit.
- `MID_SAMPLE`, `SAMPLES_PER_BIT/2 - 1` (= 7): counter value at which each bit is sampled.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `r_enable`  in  1  receiver enable; low forces and holds IDLE.
- `data_in`  in  1  serial line; idle high.
- `data_out`  out  `FRAME_BITS`  last good frame; bit 0 = first bit received (start), bit 9 = stop.
- `charReceived`  out  1  one-cycle pulse when `data_out` is updated with a good frame.
- `frameErr`  out  1  one-cycle pulse when the sampled stop bit is 0.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values (same edge as `reset` high): state = IDLE; `data_out` = 0; `charReceived` = 0; `frameErr` = 0; `busy` = 0; bit counter = 0; sample counter = 0; previous-line register = 0.
  - Because the previous-line register resets to 0, the line must be seen high for at least one cycle before a start bit is accepted.
- States:
  - IDLE → START when `r_enable`=1 and line=0 with previous line=1 (falling edge). Sample counter cleared to 0 on that cycle.
  - START: at counter = `MID_SAMPLE`:
    - line=0 → DATA; counter reset; bit index = 1; store bit 0 = 0.
    - line=1 → IDLE (false start, no pulse).
  - DATA: counter runs 0..`SAMPLES_PER_BIT`-1 and wraps. Each bit is sampled at the wrap-point cycle aligned with `MID_SAMPLE`, i.e. every `SAMPLES_PER_BIT` cycles after start confirm. Bits 1..8 go into the shift register at their index. After bit 8 → STOP.
  - STOP: sample bit 9 at the next mid-point, then:
    - sample=1 → `data_out` ← assembled frame, `charReceived`=1 next cycle, → IDLE.
    - sample=0 → `frameErr`=1 next cycle, `data_out` unchanged, → IDLE.
- `r_enable` falling in any state: next state IDLE, partial frame discarded, no pulse.
- `charReceived` and `frameErr` are mutually exclusive and never high for more than one cycle.
- Stuck-low line after a framing error does not retrigger; a new high-to-low edge is required.

## Timing
- Edge detected on cycle T (first cycle line=0 after high). Reference T is the cycle line registers low in the receiver.
- Start confirm at T+`MID_SAMPLE` (T+7).
- Bit k (1..9) sampled at T+7+16k. Stop bit sampled at T+151.
- `charReceived` / `frameErr` high on cycle T+152. `data_out` valid from T+152 and held until the next good frame.
- IDLE reached at T+152. A falling edge on T+152 or later starts a new frame, so back-to-back frames need no gap.
- `busy` high T+1 through T+151 inclusive.
- `reset` mid-frame takes effect the next edge; no pulse is generated.

## Configuration
- `RX_SYNC_EN` defined: `data_in` passes through a 2-flop synchronizer (both flops reset to 1) before edge detection and sampling. All timing above shifts by +2 cycles relative to the `data_in` port.
- `RX_SYNC_EN` undefined: `data_in` is used directly, with the timing exactly as above.

## Test plan
- Reset/idle: `reset`=1 for 2 cycles, line high → all outputs 0 and `busy`=0. Line held high 200 cycles → no pulses.
- Good frame: line high, then 10'b1010110100 sent LSB-first at 16 cycles/bit with edge at T → `charReceived`=1 at exactly T+152 (T+154 with `RX_SYNC_EN`). `data_out`=10'b1010110100; `frameErr`=0.
- False start: line low for 4 cycles then high → returns to IDLE by T+8; no pulses; `data_out` unchanged.
- Framing error: same frame with stop bit driven 0 → `frameErr`=1 at T+152; `charReceived`=0; `data_out` keeps its prior value.
- Back-to-back: two frames, 10'b1010110100 then 10'b1111111110, with no idle gap → two `charReceived` pulses 160 cycles apart; second `data_out`=10'b1111111110.
- Abort: `r_enable` dropped at T+60 → `busy`=0 next cycle, no pulse. Re-enable plus a fresh frame → received correctly.
